nanov_sequencer: RTL and testbench

NANOV_SEQUENCER -- requirements
Module: nanov_sequencer

---
 rtl/nanov_pkg.sv | 26 ++
 rtl/nanov_pass_decode.sv | 34 +++
 rtl/nanov_sequencer.sv | 154 +++++++++++++++
 tb/tb_nanov_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_pkg.sv
// Shared definitions for the nanov bit-serial instruction sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package nanov_pkg;

    // RV32 major opcodes that need a second 32-clock pass
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct3 values of the shift instructions within OP / OP-IMM
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_FIRST = 2'd0,
        RUN         = 2'd1,
        STALL       = 2'd2
    } seq_state_t;

endpackage

// File: rtl/nanov_pass_decode.sv
// Maps an instruction word to its number of 32-clock passes minus one.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module nanov_pass_decode
    import nanov_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  passes_m1
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    // register fields and immediates do not affect the pass count
    assign unused_bits = ^{instr[31:15], instr[11:7]};

    // jumps, branches and shifts need a second pass; everything else one
    always_comb begin
        passes_m1 = 3'd0;
        case (opcode)
            OPC_JAL, OPC_JALR, OPC_BRANCH: passes_m1 = 3'd1;
            OPC_OP, OPC_OP_IMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SRX) begin
                    passes_m1 = 3'd1;
                end
            end
            default: passes_m1 = 3'd0;
        endcase
    end

endmodule

// File: rtl/nanov_sequencer.sv
// Bit-serial core sequencer: fetches instructions, counts bit/pass positions, handles redirects.
// Latency: core runs 1 clk after the first fetch_ack; next word is prefetched during execution.
// Backpressure: fetch_req held until fetch_ack; core stalls at retire if the prefetch is not back.
module nanov_sequencer
    import nanov_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic        core_run,
    output logic [31:0] instr,
    output logic [30:0] next_instr,
    output logic [4:0]  counter,
    output logic [2:0]  cycle,
    output logic        pc,
    input  logic        branch,
    input  logic [31:0] target
);

    seq_state_t  state;
    logic [31:0] pc_reg;
    logic [31:0] buf_dat;
    logic        buf_vld;
    logic        redir_pend;

    logic [2:0]  passes_m1;
    logic [31:0] pc_plus4;
    logic        ack_ok;
    logic        last_bit;
    logic        final_pass;
    logic        retire;
    logic        redirect;
    logic        unused_target;

    nanov_pass_decode u_pass_decode (
        .instr     (instr),
        .passes_m1 (passes_m1)
    );

    // an ack only counts against a live request; stray acks are dropped
    assign ack_ok     = fetch_req & fetch_ack;
    assign last_bit   = (counter == 5'd31);
    assign final_pass = (cycle == passes_m1);
    assign retire     = (state == RUN) & last_bit & final_pass;
    // a branch raised in the retire cycle itself still redirects
    assign redirect   = retire & (redir_pend | branch);
    assign pc_plus4   = pc_reg + 32'd4;

    assign core_run      = (state == RUN);
    assign next_instr    = buf_dat[30:0];
    assign pc            = pc_reg[counter];
    assign unused_target = ^target[1:0];

    // sequencer state machine, fetch handshake and prefetch buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH_FIRST;
            pc_reg     <= RESET_PC;
            counter    <= 5'd0;
            cycle      <= 3'd0;
            instr      <= NOP_INSTR;
            buf_vld    <= 1'b0;
            buf_dat    <= 32'd0;
            redir_pend <= 1'b0;
            fetch_req  <= 1'b0;
            fetch_addr <= RESET_PC;
        end else begin
            case (state)
                FETCH_FIRST: begin
                    if (ack_ok) begin
                        instr     <= fetch_data;
                        fetch_req <= 1'b0;
                        counter   <= 5'd0;
                        cycle     <= 3'd0;
                        state     <= RUN;
                    end else if (!fetch_req) begin
                        fetch_req  <= 1'b1;
                        fetch_addr <= pc_reg;
                    end
                end

                RUN: begin
                    if (branch) begin
                        redir_pend <= 1'b1;
                    end
                    counter <= counter + 5'd1;
                    if (last_bit && !final_pass) begin
                        cycle <= cycle + 3'd1;
                    end

                    // prefetch: capture a returning word, or request the next one
                    if (ack_ok) begin
                        buf_vld   <= 1'b1;
                        buf_dat   <= fetch_data;
                        fetch_req <= 1'b0;
                    end else if (!buf_vld && !fetch_req) begin
                        fetch_req  <= 1'b1;
                        fetch_addr <= pc_plus4;
                    end

                    if (retire) begin
                        if (redirect) begin
                            // drop buffer and any in-flight fetch, refetch at target
                            pc_reg     <= {target[31:2], 2'b00};
                            buf_vld    <= 1'b0;
                            fetch_req  <= 1'b0;
                            redir_pend <= 1'b0;
                            counter    <= 5'd0;
                            cycle      <= 3'd0;
                            state      <= FETCH_FIRST;
                        end else if (buf_vld) begin
                            instr   <= buf_dat;
                            pc_reg  <= pc_plus4;
                            buf_vld <= 1'b0;
                            cycle   <= 3'd0;
                        end else if (ack_ok) begin
                            // word arrives exactly at retire: bypass the buffer
                            instr   <= fetch_data;
                            pc_reg  <= pc_plus4;
                            buf_vld <= 1'b0;
                            cycle   <= 3'd0;
                        end else begin
                            counter <= counter;
                            state   <= STALL;
                        end
                    end
                end

                STALL: begin
                    // counter/cycle frozen; retire completes when the word lands
                    if (ack_ok) begin
                        instr     <= fetch_data;
                        fetch_req <= 1'b0;
                        pc_reg    <= pc_plus4;
                        counter   <= 5'd0;
                        cycle     <= 3'd0;
                        state     <= RUN;
                    end else if (!fetch_req) begin
                        fetch_req  <= 1'b1;
                        fetch_addr <= pc_plus4;
                    end
                end

                default: state <= FETCH_FIRST;
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_sequencer.sv
// Directed bench for nanov_sequencer: reset, multi-pass timing, redirect, stall, bypass, reset abort.
// Latency: n/a.
// Backpressure: bench plays the fetch memory and chooses ack timing per scenario.
module tb_nanov_sequencer;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] SLLI  = 32'h0020_9093;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] DISC  = 32'h0020_0113;
    localparam logic [31:0] ADDI3 = 32'h0030_0093;
    localparam logic [31:0] W4    = 32'h0040_0093;
    localparam logic [31:0] W5    = 32'h0050_0093;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        core_run;
    logic [31:0] instr;
    logic [30:0] next_instr;
    logic [4:0]  counter;
    logic [2:0]  cycle;
    logic        pc;
    logic        branch;
    logic [31:0] target;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] pcv;

    nanov_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .core_run   (core_run),
        .instr      (instr),
        .next_instr (next_instr),
        .counter    (counter),
        .cycle      (cycle),
        .pc         (pc),
        .branch     (branch),
        .target     (target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock, sample 1 ns later, rebuild pc_reg from the serial pc bit
    task step();
        @(posedge clk);
        #1;
        if (core_run) pcv[counter] = pc;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_ack  = 1'b0;
        fetch_data = 32'd0;
        branch     = 1'b0;
        target     = 32'd0;
        pcv        = 32'hFFFF_FFFF;

        // reset state
        step();
        step();
        chk("rst_req",   {31'd0, fetch_req}, 32'd0);
        chk("rst_run",   {31'd0, core_run},  32'd0);
        chk("rst_cnt",   {27'd0, counter},   32'd0);
        chk("rst_cyc",   {29'd0, cycle},     32'd0);
        chk("rst_instr", instr,              NOP);

        // first fetch at RESET_PC, acked after 3 clks
        rst = 1'b0;
        step();
        chk("first_req",  {31'd0, fetch_req}, 32'd1);
        chk("first_addr", fetch_addr,         32'd0);
        step();
        step();
        chk("first_hold", {31'd0, fetch_req}, 32'd1);
        chk("first_wait", {31'd0, core_run},  32'd0);
        fetch_ack  = 1'b1;
        fetch_data = ADDI;
        step();
        fetch_ack = 1'b0;
        chk("addi_run",   {31'd0, core_run}, 32'd1);
        chk("addi_instr", instr,             ADDI);
        chk("addi_cnt0",  {27'd0, counter},  32'd0);

        // ADDI pass; prefetch of SLLI acked early
        for (int i = 1; i < 32; i++) begin
            step();
            chk("addi_cnt", {27'd0, counter}, i);
            if (i == 1) begin
                chk("pf_req",   {31'd0, fetch_req}, 32'd1);
                chk("pf_addr4", fetch_addr,         32'd4);
                fetch_ack  = 1'b1;
                fetch_data = SLLI;
            end else begin
                fetch_ack = 1'b0;
            end
        end
        chk("next_slli", {1'b0, next_instr}, SLLI & 32'h7FFF_FFFF);
        chk("pc_addi",   pcv,                32'd0);

        // ADDI retires after 32 clks; SLLI takes two passes
        pcv = 32'hFFFF_FFFF;
        step();
        chk("slli_instr", instr,             SLLI);
        chk("slli_run",   {31'd0, core_run}, 32'd1);
        chk("slli_cnt0",  {27'd0, counter},  32'd0);
        for (int i = 1; i < 32; i++) begin
            step();
            if (i == 1) begin
                chk("pf_addr8", fetch_addr, 32'd8);
                fetch_ack  = 1'b1;
                fetch_data = BEQ;
            end else begin
                fetch_ack = 1'b0;
            end
        end
        chk("pc_slli",     pcv,             32'd4);
        chk("slli_c0_end", {29'd0, cycle},  32'd0);
        step();
        chk("slli_pass2",  {29'd0, cycle},  32'd1);
        chk("slli_p2_cnt", {27'd0, counter}, 32'd0);
        chk("slli_p2_ins", instr,           SLLI);
        for (int i = 1; i < 32; i++) step();

        // BEQ with redirect requested at counter 31 of pass 0
        pcv = 32'hFFFF_FFFF;
        step();
        chk("beq_instr", instr,          BEQ);
        chk("beq_cyc0",  {29'd0, cycle}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            step();
            if (i == 1) begin
                chk("pf_addr12", fetch_addr, 32'd12);
                fetch_ack  = 1'b1;
                fetch_data = DISC;
            end else begin
                fetch_ack = 1'b0;
            end
            if (i == 31) begin
                branch = 1'b1;
                target = 32'h0000_0100;
            end
        end
        chk("pc_beq",    pcv,                32'd8);
        chk("next_disc", {1'b0, next_instr}, DISC & 32'h7FFF_FFFF);
        step();
        branch = 1'b0;
        chk("beq_cyc1", {29'd0, cycle}, 32'd1);
        for (int i = 1; i < 32; i++) step();
        step();
        chk("redir_run0", {31'd0, core_run}, 32'd0);
        step();
        chk("redir_req",  {31'd0, fetch_req}, 32'd1);
        chk("redir_addr", fetch_addr,         32'h0000_0100);
        step();
        chk("redir_wait", {31'd0, core_run},  32'd0);
        pcv        = 32'hFFFF_FFFF;
        fetch_ack  = 1'b1;
        fetch_data = ADDI3;
        step();
        fetch_ack = 1'b0;
        target    = 32'd0;
        chk("redir_resume", {31'd0, core_run}, 32'd1);
        chk("redir_instr",  instr,             ADDI3);
        chk("redir_cnt0",   {27'd0, counter},  32'd0);

        // prefetch of 0x104 left unacked for 40 clks -> stall at counter 31
        for (int i = 1; i < 32; i++) begin
            step();
            if (i == 1) chk("pf_addr104", fetch_addr, 32'h0000_0104);
        end
        chk("pc_target", pcv, 32'h0000_0100);
        step();
        chk("stall_run", {31'd0, core_run}, 32'd0);
        chk("stall_cnt", {27'd0, counter},  32'd31);
        for (int k = 0; k < 8; k++) step();
        chk("stall_hold", {27'd0, counter},  32'd31);
        chk("stall_req",  {31'd0, fetch_req}, 32'd1);
        chk("stall_addr", fetch_addr,         32'h0000_0104);
        chk("stall_run2", {31'd0, core_run},  32'd0);
        pcv        = 32'hFFFF_FFFF;
        fetch_ack  = 1'b1;
        fetch_data = W4;
        step();
        fetch_ack = 1'b0;
        chk("stall_resume", {31'd0, core_run}, 32'd1);
        chk("stall_instr",  instr,             W4);
        chk("stall_cnt0",   {27'd0, counter},  32'd0);

        // fetch_ack lands in the retire cycle itself
        for (int i = 1; i < 32; i++) begin
            step();
            if (i == 1) chk("pf_addr108", fetch_addr, 32'h0000_0108);
            if (i == 31) begin
                fetch_ack  = 1'b1;
                fetch_data = W5;
            end
        end
        chk("pc_stalled", pcv, 32'h0000_0104);
        step();
        fetch_ack = 1'b0;
        chk("coinc_instr", instr,             W5);
        chk("coinc_run",   {31'd0, core_run}, 32'd1);
        chk("coinc_cnt0",  {27'd0, counter},  32'd0);
        step();
        chk("pf_addr10c", fetch_addr,         32'h0000_010C);
        chk("pf_req10c",  {31'd0, fetch_req}, 32'd1);

        // reset while a fetch is outstanding, then a late ack
        rst = 1'b1;
        step();
        chk("rr_req0",  {31'd0, fetch_req}, 32'd0);
        chk("rr_run0",  {31'd0, core_run},  32'd0);
        chk("rr_instr", instr,              NOP);
        fetch_ack  = 1'b1;
        fetch_data = W4;
        step();
        rst = 1'b0;
        step();
        fetch_ack = 1'b0;
        chk("rr_req",   {31'd0, fetch_req}, 32'd1);
        chk("rr_addr",  fetch_addr,         32'd0);
        chk("rr_run",   {31'd0, core_run},  32'd0);
        step();
        chk("rr_ignored", {31'd0, core_run}, 32'd0);
        chk("rr_nop",     instr,             NOP);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
